m_mem_arbiter: RTL and testbench



---
 rtl/m_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_m_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_mem_arbiter.sv
// m_mem_arbiter: round-robin arbiter that serialises N_REQ requesters onto one
// single-port, variable-latency memory. Each transaction is latched, held on
// the memory bus until i_mem_ack or a timeout, then completed to the winner
// with a one-cycle ack.
//
// Handshake: a requester raises i_req[k] with stable we/addr/wdata and holds it
// until o_ack[k] pulses for one cycle (with o_err/o_rdata valid in that same
// cycle). The memory side sees o_mem_req held high with stable we/addr/wdata
// until the cycle i_mem_ack is sampled high; i_mem_rdata is valid in that cycle.
module m_mem_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ-1:0]      i_we,
    input  logic [32*N_REQ-1:0]   i_addr,
    input  logic [32*N_REQ-1:0]   i_wdata,
    output logic [N_REQ-1:0]      o_ack,
    output logic                  o_err,
    output logic [31:0]           o_rdata,
    output logic                  o_busy,
    output logic [2:0]            o_grant_id,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [31:0]           o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        last_q, last_d;
    logic [2:0]        grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    // Winner search and selected requester fields.
    logic              win_found;
    logic [2:0]        win_idx;
    logic [7:0]        req_pad;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [7:0]        ack_pad;

    // Round-robin search: first set request starting just after the last winner.
    always_comb begin
        int pos;
        win_found = 1'b0;
        win_idx   = '0;
        req_pad   = 8'(i_req);
        for (int i = 1; i <= N_REQ; i++) begin
            pos = int'(last_q) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!win_found && req_pad[3'(pos)]) begin
                win_found = 1'b1;
                win_idx   = 3'(pos);
            end
        end
    end

    // Mux the winning requester's transaction fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == 3'(k)) begin
                sel_we    = i_we[k];
                sel_addr  = i_addr[32*k +: 32];
                sel_wdata = i_wdata[32*k +: 32];
            end
        end
    end

    // One-hot ack pattern for the current grant.
    always_comb begin
        ack_pad = 8'b1 << grant_q;
    end

    // Next-state and registered-output logic; everything holds by default.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    grant_d     = win_idx;
                    last_d      = win_idx;
                    cnt_d       = '0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An ack on the timeout cycle still counts as a normal completion.
                if (i_mem_ack) begin
                    rdata_d   = i_mem_rdata;
                    err_d     = 1'b0;
                    mem_req_d = 1'b0;
                    ack_d     = ack_pad[N_REQ-1:0];
                    state_d   = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    ack_d     = ack_pad[N_REQ-1:0];
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                // No arbitration here, so a request still high is not regranted.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 3'(N_REQ - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_err       = err_q;
    assign o_rdata     = rdata_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_grant_id  = grant_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Bench for m_mem_arbiter: directed transactions with a scoreboard queue of
// expected completions {ack, err, rdata, grant_id}, a monitor that pops on every
// ack pulse, and a simple memory responder with a programmable wait count.
module tb_m_mem_arbiter;

  localparam int N_REQ   = 3;
  localparam int TIMEOUT = 6;
  localparam int W       = 39;

  logic                i_clk;
  logic                i_reset;
  logic [N_REQ-1:0]    i_req;
  logic [N_REQ-1:0]    i_we;
  logic [32*N_REQ-1:0] i_addr;
  logic [32*N_REQ-1:0] i_wdata;
  logic [N_REQ-1:0]    o_ack;
  logic                o_err;
  logic [31:0]         o_rdata;
  logic                o_busy;
  logic [2:0]          o_grant_id;
  logic                o_mem_req;
  logic                o_mem_we;
  logic [31:0]         o_mem_addr;
  logic [31:0]         o_mem_wdata;
  logic                i_mem_ack;
  logic [31:0]         i_mem_rdata;

  m_mem_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_ack       (o_ack),
    .o_err       (o_err),
    .o_rdata     (o_rdata),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("reset_mem_req", 64'(o_mem_req), 64'(0));
    chk("reset_ack", 64'(o_ack), 64'(0));
    chk("reset_busy_err_gid", 64'({o_busy, o_err, o_grant_id}), 64'(0));
    chk("reset_rdata_addr", {o_rdata, o_mem_addr}, 64'(0));
    i_reset = 1'b0;
  endtask

  // ---------------- memory responder ----------------
  int          mem_wait = -1;
  int          acc_cnt = 0;
  logic        resp_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] resp_rdata = '0;

  assign i_mem_ack   = resp_ack | man_ack;
  assign i_mem_rdata = resp_rdata;

  // Acks on the (mem_wait+1)-th cycle of o_mem_req; read data is ~address.
  always @(negedge i_clk) begin
    if (o_mem_req) begin
      resp_ack   = (acc_cnt == mem_wait);
      resp_rdata = ~o_mem_addr;
      acc_cnt++;
    end else begin
      acc_cnt  = 0;
      resp_ack = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [N_REQ-1:0] prev_ack = '0;
  logic [W-1:0]     exp_item;

  always @(negedge i_clk) begin
    if (o_ack != '0) begin
      chk("ack_single_cycle", 64'(prev_ack), 64'(0));
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_ack: got ack=%b gid=%0d expected none", o_ack, o_grant_id);
      end else begin
        exp_item = exp_q.pop_front();
        chk("completion", 64'({o_ack, o_err, o_rdata, o_grant_id}), 64'(exp_item));
      end
    end
    prev_ack = o_ack;
  end

  function automatic logic [W-1:0] mk_exp(input int k, input logic err, input logic [31:0] rd);
    logic [2:0] oh;
    oh = 3'b001 << k;
    return {oh, err, rd, 3'(k)};
  endfunction

  // ---------------- driver ----------------
  // One transaction from requester k; returns negedges until ack and the
  // number of cycles o_mem_req was high. Fields are scrambled during ACCESS.
  task automatic txn(input int k, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int wait_c, input logic exp_err,
                     output int lat, output int hi);
    logic done;
    mem_wait = wait_c;
    @(negedge i_clk);
    i_we[k]               = we;
    i_addr[32*k +: 32]    = addr;
    i_wdata[32*k +: 32]   = wdata;
    i_req[k]              = 1'b1;
    exp_q.push_back(mk_exp(k, exp_err, exp_err ? 32'h0 : ~addr));
    lat  = 0;
    hi   = 0;
    done = 1'b0;
    while (!done && lat < 60) begin
      @(negedge i_clk);
      lat++;
      if (o_mem_req) begin
        hi++;
        chk("mem_fields_stable", {o_mem_we, o_mem_addr, o_mem_wdata[30:0]},
            {we, addr, wdata[30:0]});
        i_addr[32*k +: 32]  = ~addr;
        i_wdata[32*k +: 32] = addr;
        i_we[k]             = ~we;
      end
      if (o_ack[k]) begin
        done     = 1'b1;
        i_req[k] = 1'b0;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL txn_timeout: no ack for requester %0d within %0d cycles", k, lat);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, hi, cyc, acks;
    logic [N_REQ-1:0] pend;
    i_reset = 1'b1;
    i_req   = '0;
    i_we    = '0;
    i_addr  = '0;
    i_wdata = '0;
    do_reset();

    // Single read: mem_req in cycle 1, ack in cycle 2, idle in cycle 3.
    txn(0, 1'b0, 32'h0000_0100, 32'h0, 0, 1'b0, lat, hi);
    chk("t1_latency", 64'(lat), 64'(2));
    chk("t1_mem_cycles", 64'(hi), 64'(1));
    @(negedge i_clk);
    chk("t1_busy_low", 64'(o_busy), 64'(0));
    chk("t1_rdata_hold", 64'(o_rdata), 64'(32'hFFFF_FEFF));

    // Round robin with all three requesting, two memory wait cycles.
    do_reset();
    mem_wait = 2;
    i_we = '0;
    for (int k = 0; k < N_REQ; k++) i_addr[32*k +: 32] = 32'h400 + 32'(4*k);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N_REQ; k++)
        exp_q.push_back(mk_exp(k, 1'b0, ~(32'h400 + 32'(4*k))));
    @(negedge i_clk);
    i_req = 3'b111;
    pend  = '0;
    cyc   = 0;
    acks  = 0;
    while (acks < 6 && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
      i_req = i_req | pend;
      pend  = '0;
      if (o_ack != '0) begin
        acks++;
        if (acks < 6) begin
          i_req = i_req & ~o_ack;
          pend  = o_ack;
        end else begin
          i_req = '0;
        end
      end
    end
    chk("rr_ack_count", 64'(acks), 64'(6));
    @(negedge i_clk);

    // Write from requester 1, acked on the 4th ACCESS cycle.
    txn(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 3, 1'b0, lat, hi);
    chk("wr_mem_cycles", 64'(hi), 64'(4));

    // Timeout: memory never acks.
    txn(2, 1'b0, 32'h0000_3000, 32'h0, -1, 1'b1, lat, hi);
    chk("to_mem_cycles", 64'(hi), 64'(TIMEOUT));
    chk("to_latency", 64'(lat), 64'(TIMEOUT + 1));

    // Ack on the last allowed cycle wins over timeout.
    txn(2, 1'b0, 32'h0000_3004, 32'h0, TIMEOUT - 1, 1'b0, lat, hi);
    chk("ack_at_limit_cycles", 64'(hi), 64'(TIMEOUT));

    // Reset on the 2nd ACCESS cycle; late ack ignored; next grant to 0.
    mem_wait = -1;
    @(negedge i_clk);
    i_addr[31:0] = 32'h0000_0500;
    i_we         = '0;
    i_req        = 3'b001;
    cyc = 0;
    while (!o_mem_req && cyc < 20) begin
      @(negedge i_clk);
      cyc++;
    end
    chk("rst_saw_mem_req", 64'(o_mem_req), 64'(1));
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("rst_mem_req_drop", 64'(o_mem_req), 64'(0));
    chk("rst_no_ack", 64'({o_ack, o_busy}), 64'(0));
    i_reset = 1'b0;
    i_req   = '0;
    man_ack = 1'b1;
    @(negedge i_clk);
    man_ack = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_idle_after_late_ack", 64'(o_busy), 64'(0));
    mem_wait = 0;
    exp_q.push_back(mk_exp(0, 1'b0, 32'hFFFF_FAFF));
    i_req = 3'b111;
    cyc = 0;
    while (o_ack == '0 && cyc < 20) begin
      @(negedge i_clk);
      cyc++;
    end
    i_req = '0;
    chk("rst_next_grant", 64'(o_grant_id), 64'(0));
    repeat (4) @(negedge i_clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
